// File: rtl/sram_bank_responder.sv
// Bank of independent SRAMs answering the memory controller's per-RAM strobes, with a clear sweep per RAM.
// Optional macro SRAM_WRITE_FIRST_BYPASS_EN: when defined, a same-address read/write collision returns the new write data.
module sram_bank_responder #(
  parameter int Addr_Width    = 4,
  parameter int Ram_Depth     = 1 << Addr_Width,
  parameter int Nums_SRAM_In  = 2,
  parameter int Nums_SRAM_Out = 1,
  parameter int Nums_SRAM     = Nums_SRAM_In + Nums_SRAM_Out,
  parameter int Data_Width    = 8
) (
  input  logic                             clk,
  input  logic                             Mem_reset,
  input  logic [Nums_SRAM-1:0]             Mem_Clear,
  input  logic [Nums_SRAM-1:0]             En_Chip_Select,
  input  logic [Nums_SRAM-1:0]             En_Write,
  input  logic [Nums_SRAM-1:0]             En_Read,
  input  logic [Nums_SRAM*Addr_Width-1:0]  Addr_Read,
  input  logic [Nums_SRAM*Addr_Width-1:0]  Addr_Write,
  input  logic [Nums_SRAM*Data_Width-1:0]  Data_Write,
  output logic [Nums_SRAM*Data_Width-1:0]  Data_Read,
  output logic [Nums_SRAM-1:0]             Read_Valid,
  output logic [Nums_SRAM-1:0]             Clear_Busy
);

  typedef enum logic {IDLE, CLEAR} ram_state_e;

  for (genvar i = 0; i < Nums_SRAM; i++) begin : g_ram
    ram_state_e             state, state_next;
    logic [Addr_Width-1:0]  cnt, cnt_next;
    logic [Data_Width-1:0]  mem [Ram_Depth];
    logic                   wr_en, rd_en, mem_we;
    logic [Addr_Width-1:0]  raddr, waddr, mem_addr;
    logic [Data_Width-1:0]  wdata, mem_wdata, rd_word;
    logic [Data_Width-1:0]  rd_data_p0;
    logic                   vld_p0;

    assign raddr = Addr_Read[Addr_Width*i +: Addr_Width];
    assign waddr = Addr_Write[Addr_Width*i +: Addr_Width];
    assign wdata = Data_Write[Data_Width*i +: Data_Width];

    // A clear request in IDLE pre-empts any access issued in the same cycle.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      case (state)
        IDLE: begin
          if (Mem_Clear[i]) begin
            state_next = CLEAR;
            cnt_next   = '0;
          end else begin
            wr_en = En_Chip_Select[i] & En_Write[i];
            rd_en = En_Chip_Select[i] & En_Read[i];
          end
        end
        CLEAR: begin
          cnt_next = cnt + 1'b1;
          if (cnt == Addr_Width'(Ram_Depth - 1)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    always_comb begin
      mem_we    = (state == CLEAR) | wr_en;
      mem_addr  = (state == CLEAR) ? cnt : waddr;
      mem_wdata = (state == CLEAR) ? '0 : wdata;
    end

`ifdef SRAM_WRITE_FIRST_BYPASS_EN
    assign rd_word = (wr_en && (waddr == raddr)) ? wdata : mem[raddr];
`else
    assign rd_word = mem[raddr];
`endif

    // Stage p0: registered read data and its valid flag.
    always_ff @(posedge clk) begin
      if (Mem_reset) begin
        state      <= IDLE;
        cnt        <= '0;
        vld_p0     <= 1'b0;
        rd_data_p0 <= '0;
      end else begin
        state  <= state_next;
        cnt    <= cnt_next;
        vld_p0 <= rd_en;
        if (rd_en) rd_data_p0 <= rd_word;
      end
    end

    // Array contents survive reset; a reset edge simply performs no write.
    always_ff @(posedge clk) begin
      if (!Mem_reset && mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign Data_Read[Data_Width*i +: Data_Width] = rd_data_p0;
    assign Read_Valid[i] = vld_p0;
    assign Clear_Busy[i] = (state == CLEAR);
  end

endmodule

// File: tb/tb_sram_bank_responder.sv
// Self-checking bench for sram_bank_responder: directed steps plus a random phase against a per-cycle reference model.
module tb_sram_bank_responder;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N = 3;
  localparam int DEPTH = 16;
`ifdef SRAM_WRITE_FIRST_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            Mem_reset;
  logic [N-1:0]    Mem_Clear, En_Chip_Select, En_Write, En_Read;
  logic [N*AW-1:0] Addr_Read, Addr_Write;
  logic [N*DW-1:0] Data_Write, Data_Read;
  logic [N-1:0]    Read_Valid, Clear_Busy;

  sram_bank_responder #(
    .Addr_Width(AW), .Nums_SRAM_In(2), .Nums_SRAM_Out(1), .Data_Width(DW)
  ) dut (
    .clk(clk), .Mem_reset(Mem_reset), .Mem_Clear(Mem_Clear),
    .En_Chip_Select(En_Chip_Select), .En_Write(En_Write), .En_Read(En_Read),
    .Addr_Read(Addr_Read), .Addr_Write(Addr_Write), .Data_Write(Data_Write),
    .Data_Read(Data_Read), .Read_Valid(Read_Valid), .Clear_Busy(Clear_Busy)
  );

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0]   ref_mem [N][DEPTH];
  int              busy_left [N];
  int              clr_ptr [N];
  logic [N*DW-1:0] exp_rd;
  logic [N-1:0]    exp_rv, exp_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, from the currently driven inputs.
  task automatic model_edge();
    if (Mem_reset) begin
      exp_rd = '0;
      exp_rv = '0;
      for (int i = 0; i < N; i++) begin
        busy_left[i] = 0;
        clr_ptr[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        ra = Addr_Read[i*AW +: AW];
        wa = Addr_Write[i*AW +: AW];
        wd = Data_Write[i*DW +: DW];
        exp_rv[i] = 1'b0;
        if (busy_left[i] > 0) begin
          ref_mem[i][clr_ptr[i]] = '0;
          clr_ptr[i]++;
          busy_left[i]--;
        end else if (Mem_Clear[i]) begin
          busy_left[i] = DEPTH;
          clr_ptr[i] = 0;
        end else if (En_Chip_Select[i]) begin
          if (En_Read[i]) begin
            exp_rv[i] = 1'b1;
            exp_rd[i*DW +: DW] = (BYPASS && En_Write[i] && wa == ra) ? wd : ref_mem[i][ra];
          end
          if (En_Write[i]) ref_mem[i][wa] = wd;
        end
      end
    end
    for (int i = 0; i < N; i++) exp_busy[i] = (busy_left[i] > 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("data_read", 32'(Data_Read), 32'(exp_rd));
    check("read_valid", 32'(Read_Valid), 32'(exp_rv));
    check("clear_busy", 32'(Clear_Busy), 32'(exp_busy));
  endtask

  task automatic idle_inputs();
    Mem_reset = 1'b0;
    Mem_Clear = '0;
    En_Chip_Select = '0;
    En_Write = '0;
    En_Read = '0;
    Addr_Read = '0;
    Addr_Write = '0;
    Data_Write = '0;
  endtask

  task automatic drive_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    En_Chip_Select[i] = 1'b1;
    En_Write[i] = 1'b1;
    Addr_Write[i*AW +: AW] = a;
    Data_Write[i*DW +: DW] = d;
  endtask

  task automatic drive_rd(input int i, input logic [AW-1:0] a);
    En_Chip_Select[i] = 1'b1;
    En_Read[i] = 1'b1;
    Addr_Read[i*AW +: AW] = a;
  endtask

  initial begin
    exp_rd = '0;
    exp_rv = '0;
    exp_busy = '0;
    for (int i = 0; i < N; i++) begin
      busy_left[i] = 0;
      clr_ptr[i] = 0;
      for (int a = 0; a < DEPTH; a++) ref_mem[i][a] = 'x;
    end
    idle_inputs();

    // Reset, then clear every RAM.
    Mem_reset = 1'b1;
    cycle();
    cycle();
    check("reset_data_read", 32'(Data_Read), 32'h0);
    check("reset_valid", 32'(Read_Valid), 32'h0);
    check("reset_busy", 32'(Clear_Busy), 32'h0);
    Mem_reset = 1'b0;
    Mem_Clear = 3'b111;
    cycle();
    Mem_Clear = '0;
    check("clear_busy_first", 32'(Clear_Busy), 32'h7);
    for (int k = 0; k < 15; k++) begin
      cycle();
      check("clear_busy_hold", 32'(Clear_Busy), 32'h7);
    end
    cycle();
    check("clear_busy_done", 32'(Clear_Busy), 32'h0);
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs();
      for (int i = 0; i < N; i++) drive_rd(i, 4'(a));
      cycle();
      check("cleared_word", 32'(Data_Read), 32'h0);
      check("cleared_valid", 32'(Read_Valid), 32'h7);
    end

    // Write then read on RAM1.
    idle_inputs();
    drive_wr(1, 4'd7, 8'hA5);
    cycle();
    idle_inputs();
    drive_rd(1, 4'd7);
    cycle();
    check("wr_rd_data", 32'(Data_Read[15:8]), 32'hA5);
    check("wr_rd_valid", 32'(Read_Valid), 32'h2);

    // Write with chip-select low has no effect.
    idle_inputs();
    drive_wr(0, 4'd2, 8'h3C);
    En_Chip_Select[0] = 1'b0;
    cycle();
    idle_inputs();
    drive_rd(0, 4'd2);
    cycle();
    check("cs_gate_data", 32'(Data_Read[7:0]), 32'h00);

    // Same-address read/write collision on RAM2.
    idle_inputs();
    drive_wr(2, 4'd5, 8'h11);
    cycle();
    idle_inputs();
    drive_wr(2, 4'd5, 8'h22);
    drive_rd(2, 4'd5);
    cycle();
    check("collision_data", 32'(Data_Read[23:16]), BYPASS ? 32'h22 : 32'h11);
    idle_inputs();
    drive_rd(2, 4'd5);
    cycle();
    check("collision_after", 32'(Data_Read[23:16]), 32'h22);

    // Clear on RAM0 while traffic is issued.
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs();
      drive_wr(0, 4'(a), 8'hFF);
      cycle();
    end
    idle_inputs();
    Mem_Clear[0] = 1'b1;
    drive_rd(0, 4'd3);
    cycle();
    check("clear_drops_read", 32'(Read_Valid[0]), 32'h0);
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      drive_wr(0, 4'($urandom_range(0, 15)), 8'($urandom));
      drive_rd(0, 4'($urandom_range(0, 15)));
      cycle();
    end
    check("clear_traffic_idle", 32'(Clear_Busy[0]), 32'h0);
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs();
      drive_rd(0, 4'(a));
      cycle();
      check("clear_traffic_word", 32'(Data_Read[7:0]), 32'h00);
    end

    // Reset in the middle of a RAM0 sweep.
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs();
      drive_wr(0, 4'(a), 8'hFF);
      cycle();
    end
    idle_inputs();
    Mem_Clear[0] = 1'b1;
    cycle();
    Mem_Clear[0] = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    Mem_reset = 1'b1;
    cycle();
    check("mid_clear_abort", 32'(Clear_Busy), 32'h0);
    Mem_reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs();
      drive_rd(0, 4'(a));
      cycle();
      check("mid_clear_word", 32'(Data_Read[7:0]), (a < 5) ? 32'h00 : 32'hFF);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      idle_inputs();
      Mem_reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        Mem_Clear[i] = ($urandom_range(0, 39) == 0);
        En_Chip_Select[i] = ($urandom_range(0, 3) != 0);
        En_Write[i] = $urandom_range(0, 1);
        En_Read[i] = $urandom_range(0, 1);
        Addr_Write[i*AW +: AW] = 4'($urandom_range(0, 15));
        Addr_Read[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? Addr_Write[i*AW +: AW]
                                                             : 4'($urandom_range(0, 15));
        Data_Write[i*DW +: DW] = 8'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
